gc_click_tx: RTL

Transmitter side of the 64-bit gate-count/click stream that `ddr_data` receives on `s_axis_tdata_gc`. It runs in the 200 MHz domain and keeps a 48-bit gate counter (gc) aligned to PPS, advancing once per gate tick. Each detector event is classified against two gate windows, and every valid click is packed with its gc into a 64-bit word. Words are buffered in a small FIFO and sent on an AXI-Stream master. It sits between the time-to-digital front end (`tvalid200`/`tdata200_mod`) and the gc input of `ddr_data`.

---
 rtl/gc_pkg.sv | 28 ++
 rtl/gc_click_tx_if.sv | 11 +
 rtl/gc_word_fifo.sv | 56 +++++
 rtl/gc_click_tx.sv | 128 ++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared types and constants for the gate-count/click transmitter.
package gc_pkg;

   localparam int GC_W      = 48;
   localparam int WORD_W    = 64;
   localparam int GC_LSB    = 0;
   localparam int CLICK_LSB = 48;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_PPS = 2'd1,
      ST_RUN      = 2'd2
   } gc_tx_state_t;

   typedef struct packed {
      logic [WORD_W-CLICK_LSB-3:0] rsvd;
      logic [1:0]                  click;
      logic [CLICK_LSB-1:0]        gc;
   } gc_word_t;

   // Half-open window [lo, hi); lo >= hi can never match.
   function automatic logic in_window(input logic [15:0] v,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/gc_click_tx_if.sv
// AXI-Stream bundle carrying the 64-bit gc/click words.
interface gc_click_tx_if;
   import gc_pkg::*;

   logic [WORD_W-1:0] m_axis_tdata_gc;
   logic              m_axis_tvalid_gc;
   logic              m_axis_tready_gc;

   modport master (output m_axis_tdata_gc, output m_axis_tvalid_gc, input m_axis_tready_gc);
   modport slave  (input m_axis_tdata_gc, input m_axis_tvalid_gc, output m_axis_tready_gc);
endinterface

// File: rtl/gc_word_fifo.sv
// Synchronous word FIFO; read data is combinational from the head slot.
// A write while full is accepted only if a read happens in the same cycle.
module gc_word_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_en,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;

   always_comb begin
      full     = (cnt_q == FULL_CNT);
      empty    = (cnt_q == '0);
      do_rd    = rd_en & ~empty;
      do_wr    = wr_en & (~full | do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({do_wr, do_rd})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      rd_dat   = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
   end

endmodule

// File: rtl/gc_click_tx.sv
// PPS-aligned gate counter; events are windowed, packed with gc and streamed out.
// Event to tvalid is 3 cycles; output holds under backpressure, FIFO overflow is counted.
module gc_click_tx #(
   parameter int FIFO_DEPTH = 16,
   parameter int GC_W       = 48
) (
   input  logic              clk200_i,
   input  logic              gc_tx_rstn,
   input  logic              pps_i,
   input  logic              gc_tick_i,
   input  logic              tvalid200,
   input  logic [15:0]       tdata200_mod,
   input  logic [31:0]       gate_pos0,
   input  logic [31:0]       gate_pos1,
   input  logic [31:0]       gate_pos2,
   input  logic [31:0]       gate_pos3,
   input  logic              sr_start_i,
   input  logic [GC_W-1:0]   sr_dq_gc_start_i,
   gc_click_tx_if.master     m_axis,
   output logic [GC_W-1:0]   sr_current_gc,
   output logic [15:0]       sr_drop_count,
   output logic [1:0]        state_o
);
   import gc_pkg::*;

   gc_tx_state_t      state_q, state_d;
   logic              pps_q, pps_prev_q, pps_rise, run;
   logic [GC_W-1:0]   gc_q, gc_d;
   logic [1:0]        click;
   logic              cls_vld_q, cls_vld_d;
   gc_word_t          cls_dat_q, cls_dat_d;
   logic              out_vld_q, out_vld_d;
   logic [WORD_W-1:0] out_dat_q, out_dat_d, fifo_rd_dat;
   logic [15:0]       drop_q, drop_d;
   logic              fifo_full, fifo_empty, fifo_pop, drop;
   logic              unused_pos_hi;

   assign unused_pos_hi = ^{gate_pos0[31:16], gate_pos1[31:16], gate_pos2[31:16], gate_pos3[31:16]};
   assign pps_rise      = pps_q & ~pps_prev_q;

   always_ff @(posedge clk200_i or negedge gc_tx_rstn) begin
      if (!gc_tx_rstn) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!sr_start_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:     state_d = ST_WAIT_PPS;
            ST_WAIT_PPS: if (pps_rise) state_d = ST_RUN;
            ST_RUN:      state_d = ST_RUN;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      state_o = state_q;
      run     = (state_q == ST_RUN);
   end

   always_comb begin
      gc_d = gc_q;
      if (state_q == ST_WAIT_PPS && state_d == ST_RUN) gc_d = sr_dq_gc_start_i;
      else if (run && gc_tick_i)                       gc_d = gc_q + 1'b1;

      click[0]  = in_window(tdata200_mod, gate_pos0[15:0], gate_pos1[15:0]);
      click[1]  = in_window(tdata200_mod, gate_pos2[15:0], gate_pos3[15:0]);
      cls_vld_d = run & tvalid200 & (|click);
      // gc_q is sampled before this cycle's tick is applied.
      cls_dat_d = '{rsvd: '0, click: click, gc: 48'(gc_q)};

      fifo_pop  = ~fifo_empty & (~out_vld_q | m_axis.m_axis_tready_gc);
      drop      = cls_vld_q & fifo_full & ~fifo_pop;
      drop_d    = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;
      if (fifo_pop) begin
         out_vld_d = 1'b1;
         out_dat_d = fifo_rd_dat;
      end else if (m_axis.m_axis_tready_gc) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk200_i or negedge gc_tx_rstn) begin
      if (!gc_tx_rstn) begin
         pps_q      <= 1'b0;
         pps_prev_q <= 1'b0;
         gc_q       <= '0;
         cls_vld_q  <= 1'b0;
         cls_dat_q  <= '0;
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         drop_q     <= '0;
      end else begin
         pps_q      <= pps_i;
         pps_prev_q <= pps_q;
         gc_q       <= gc_d;
         cls_vld_q  <= cls_vld_d;
         cls_dat_q  <= cls_dat_d;
         out_vld_q  <= out_vld_d;
         out_dat_q  <= out_dat_d;
         drop_q     <= drop_d;
      end
   end

   gc_word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
      .clk    (clk200_i),
      .rst_n  (gc_tx_rstn),
      .wr_en  (cls_vld_q),
      .wr_dat (cls_dat_q),
      .rd_en  (fifo_pop),
      .rd_dat (fifo_rd_dat),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign m_axis.m_axis_tdata_gc  = out_dat_q;
   assign m_axis.m_axis_tvalid_gc = out_vld_q;
   assign sr_current_gc           = gc_q;
   assign sr_drop_count           = drop_q;

endmodule
